dual_result_monitor: RTL and testbench

- Clocked, synthesizable receiving end of the stimulus -> DUT -> check path.
- Accepts paired result words from two implementations of the same block (a VHDL reference and a Verilog DUT) over a valid/ready handshake.
- Ignores words during a programmable settle window, compares the rest, counts mismatches and captures the first failing triple.
- Reports a pass/fail verdict after a programmed number of compares.

---
 rtl/dual_result_monitor_pkg.sv | 23 ++
 rtl/dual_result_monitor_sat_counter.sv | 47 ++++
 rtl/dual_result_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_dual_result_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_result_monitor_pkg.sv
// -----------------------------------------------------------------------------
// dual_result_monitor_pkg
// Shared types and defaults for the dual result monitor:
//   - drm_state_e    : monitor FSM states (IDLE, SETTLE, RUN, DONE)
//   - DRM_W_DEF      : default result/stimulus word width
//   - DRM_CNT_W_DEF  : default compare/error counter width
//   - DRM_MASK_DEF   : all-ones compare mask for the default word width
// -----------------------------------------------------------------------------
package dual_result_monitor_pkg;

    localparam int DRM_W_DEF     = 16;
    localparam int DRM_CNT_W_DEF = 16;

    localparam logic [DRM_W_DEF-1:0] DRM_MASK_DEF = {DRM_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } drm_state_e;

endpackage

// File: rtl/dual_result_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// dual_result_monitor_sat_counter
// CNT_W-bit registered counter with synchronous clear and saturating increment.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset (count -> 0)
//   clr   in  synchronous clear, wins over inc
//   inc   in  increment by one unless already all ones
//   count out registered count value
// -----------------------------------------------------------------------------
module dual_result_monitor_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, otherwise increment and stick at all ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dual_result_monitor.sv
// -----------------------------------------------------------------------------
// dual_result_monitor
// Receives paired result words (reference and DUT implementation of the same
// block) over valid/ready, discards SETTLE words after start, compares the
// remaining num_cmp words under CMP_MASK, counts mismatches, captures the
// first failing (a, o_ref, o_dut) triple and reports a pass/fail verdict.
//
// Optional feature macro: DUAL_RESULT_MONITOR_STOP_ON_ERROR_EN
//   defined   : first mismatch ends the run (RUN -> DONE, pass=0)
//   undefined : the run always performs num_cmp compares
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_cmp      one-cycle run start, compares required (sampled on start)
//   in_valid, in_ready  word handshake; in_ready depends on state only
//   a, o_ref, o_dut     stimulus word, reference result, DUT result
//   cmp_count           compares performed this run
//   err_count           mismatches this run (saturating)
//   err_flag            sticky mismatch flag
//   first_a/ref/dut     triple of the first mismatch
//   done, pass          run complete (held until next start), verdict
// -----------------------------------------------------------------------------
module dual_result_monitor
    import dual_result_monitor_pkg::*;
#(
    parameter int            W        = DRM_W_DEF,
    parameter int            SETTLE   = 2,
    parameter int            CNT_W    = DRM_CNT_W_DEF,
    parameter logic [W-1:0]  CMP_MASK = {W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cmp,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     o_ref,
    input  logic [W-1:0]     o_dut,
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [W-1:0]     first_a,
    output logic [W-1:0]     first_ref,
    output logic [W-1:0]     first_dut,
    output logic             done,
    output logic             pass
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    drm_state_e       state_q,     state_d;
    logic [SET_W-1:0] settle_q,    settle_d;
    logic [CNT_W-1:0] num_cmp_q,   num_cmp_d;
    logic             err_flag_q,  err_flag_d;
    logic [W-1:0]     first_a_q,   first_a_d;
    logic [W-1:0]     first_ref_q, first_ref_d;
    logic [W-1:0]     first_dut_q, first_dut_d;
    logic             done_q,      done_d;
    logic             pass_q,      pass_d;

    logic             accept_s;
    logic             mismatch_s;
    logic             stop_s;
    logic             last_s;
    logic             cnt_clr_s;
    logic             cmp_inc_s;
    logic             err_inc_s;
    logic [CNT_W-1:0] cmp_count_s;
    logic [CNT_W-1:0] err_count_s;

    assign in_ready   = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign accept_s   = in_valid && in_ready;
    assign mismatch_s = |((o_ref ^ o_dut) & CMP_MASK);
    // cmp_count is always below num_cmp in RUN, so the +1 cannot wrap.
    assign last_s     = ((cmp_count_s + CNT_W'(1'b1)) == num_cmp_q);

`ifdef DUAL_RESULT_MONITOR_STOP_ON_ERROR_EN
    assign stop_s = mismatch_s;
`else
    assign stop_s = 1'b0;
`endif

    // Next-state, capture and verdict logic for the run FSM.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        num_cmp_d   = num_cmp_q;
        err_flag_d  = err_flag_q;
        first_a_d   = first_a_q;
        first_ref_d = first_ref_q;
        first_dut_d = first_dut_q;
        done_d      = done_q;
        pass_d      = pass_q;
        cnt_clr_s   = 1'b0;
        cmp_inc_s   = 1'b0;
        err_inc_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_cmp_d   = num_cmp;
                    settle_d    = SET_W'(SETTLE);
                    cnt_clr_s   = 1'b1;
                    err_flag_d  = 1'b0;
                    first_a_d   = {W{1'b0}};
                    first_ref_d = {W{1'b0}};
                    first_dut_d = {W{1'b0}};
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    if (SETTLE != 0) begin
                        state_d = ST_SETTLE;
                    end else if (num_cmp == {CNT_W{1'b0}}) begin
                        // Nothing to discard and nothing to compare.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_SETTLE: begin
                if (accept_s) begin
                    if (settle_q == SET_W'(1'b1)) begin
                        if (num_cmp_q == {CNT_W{1'b0}}) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = ~err_flag_q;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        settle_d = settle_q - SET_W'(1'b1);
                    end
                end else begin
                    settle_d = settle_q;
                end
            end

            ST_RUN: begin
                if (accept_s) begin
                    cmp_inc_s = 1'b1;
                    if (mismatch_s) begin
                        err_inc_s  = 1'b1;
                        err_flag_d = 1'b1;
                        if (!err_flag_q) begin
                            first_a_d   = a;
                            first_ref_d = o_ref;
                            first_dut_d = o_dut;
                        end else begin
                            first_a_d   = first_a_q;
                        end
                    end else begin
                        err_inc_s = 1'b0;
                    end
                    if (last_s || stop_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = ~(err_flag_q | mismatch_s);
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= {SET_W{1'b0}};
            num_cmp_q   <= {CNT_W{1'b0}};
            err_flag_q  <= 1'b0;
            first_a_q   <= {W{1'b0}};
            first_ref_q <= {W{1'b0}};
            first_dut_q <= {W{1'b0}};
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            num_cmp_q   <= num_cmp_d;
            err_flag_q  <= err_flag_d;
            first_a_q   <= first_a_d;
            first_ref_q <= first_ref_d;
            first_dut_q <= first_dut_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Compare counter: never exceeds num_cmp, so saturation is unreachable.
    dual_result_monitor_sat_counter #(.CNT_W(CNT_W)) u_cmp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (cmp_inc_s),
        .count (cmp_count_s)
    );

    dual_result_monitor_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (err_inc_s),
        .count (err_count_s)
    );

    assign cmp_count = cmp_count_s;
    assign err_count = err_count_s;
    assign err_flag  = err_flag_q;
    assign first_a   = first_a_q;
    assign first_ref = first_ref_q;
    assign first_dut = first_dut_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_dual_result_monitor.sv
// -----------------------------------------------------------------------------
// tb_dual_result_monitor
// Two monitor instances (full mask and 16'hFFF0 mask) with independent
// handshakes fed from one generated word stream. A transaction-level model
// derives each run's expected accept count, counters, first-mismatch triple
// and verdict directly from the stream.
// -----------------------------------------------------------------------------
module tb_dual_result_monitor;
    import dual_result_monitor_pkg::*;

    localparam int            W      = 16;
    localparam int            CNT_W  = 16;
    localparam int            SETTLE = 2;
    localparam int            MAXW   = 512;
    localparam logic [W-1:0]  MASK_M = 16'hFFF0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_cmp;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [W-1:0]     a_v       [2];
    logic [W-1:0]     ref_v     [2];
    logic [W-1:0]     dut_v     [2];
    logic [CNT_W-1:0] cmp_count [2];
    logic [CNT_W-1:0] err_count [2];
    logic             err_flag  [2];
    logic [W-1:0]     first_a   [2];
    logic [W-1:0]     first_ref [2];
    logic [W-1:0]     first_dut [2];
    logic             done      [2];
    logic             pass      [2];

    logic [W-1:0]     s_a [MAXW];
    logic [W-1:0]     s_r [MAXW];
    logic [W-1:0]     s_d [MAXW];

    int               needed [2];
    logic [CNT_W-1:0] e_cmp  [2];
    logic [CNT_W-1:0] e_err  [2];
    logic             e_flag [2];
    logic [W-1:0]     e_fa   [2];
    logic [W-1:0]     e_fr   [2];
    logic [W-1:0]     e_fd   [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_result_monitor #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut_full (
        .clk(clk), .rst(rst), .start(start), .num_cmp(num_cmp),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_v[0]), .o_ref(ref_v[0]), .o_dut(dut_v[0]),
        .cmp_count(cmp_count[0]), .err_count(err_count[0]), .err_flag(err_flag[0]),
        .first_a(first_a[0]), .first_ref(first_ref[0]), .first_dut(first_dut[0]),
        .done(done[0]), .pass(pass[0])
    );

    dual_result_monitor #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W), .CMP_MASK(MASK_M)) u_dut_mask (
        .clk(clk), .rst(rst), .start(start), .num_cmp(num_cmp),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_v[1]), .o_ref(ref_v[1]), .o_dut(dut_v[1]),
        .cmp_count(cmp_count[1]), .err_count(err_count[1]), .err_flag(err_flag[1]),
        .first_a(first_a[1]), .first_ref(first_ref[1]), .first_dut(first_dut[1]),
        .done(done[1]), .pass(pass[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one run on instance j, straight from the stream.
    task automatic model(input int j, input logic [W-1:0] m, input int num);
        int  cmp   = num;
        int  errs  = 0;
        bit  flag  = 1'b0;
        e_fa[j] = '0; e_fr[j] = '0; e_fd[j] = '0;
        for (int i = 0; i < num; i++) begin
            int w = SETTLE + i;
            if (((s_r[w] ^ s_d[w]) & m) != '0) begin
                if (!flag) begin
                    e_fa[j] = s_a[w]; e_fr[j] = s_r[w]; e_fd[j] = s_d[w];
                end
                flag = 1'b1;
                if (errs < 65535) errs++;
`ifdef DUAL_RESULT_MONITOR_STOP_ON_ERROR_EN
                cmp = i + 1;
                break;
`endif
            end
        end
        needed[j] = SETTLE + cmp;
        e_cmp[j]  = CNT_W'(cmp);
        e_err[j]  = CNT_W'(errs);
        e_flag[j] = flag;
    endtask

    // Word stream patterns:
    // 0 equal, 1 fault at run word 37, 2 faults in settle words only,
    // 3 low-nibble differences only, 4 random sparse faults, 5 fault at compare 5.
    task automatic build_stream(input int mode);
        for (int w = 0; w < MAXW; w++) begin
            logic [W-1:0] x;
            x = W'($urandom);
            s_a[w] = x;
            case (mode)
                3: begin
                    s_r[w] = W'($urandom);
                    s_d[w] = s_r[w] ^ W'($urandom_range(0, 15));
                end
                4: begin
                    s_r[w] = W'($urandom);
                    s_d[w] = s_r[w];
                    if ($urandom_range(0, 9) == 0) s_d[w] = s_r[w] ^ W'(1 << $urandom_range(0, 15));
                end
                default: begin
                    s_r[w] = x & 16'hAAAA;
                    s_d[w] = x & 16'hAAAA;
                end
            endcase
            if (mode == 1 && w == SETTLE + 37) s_d[w] = s_r[w] ^ 16'h0004;
            if (mode == 2 && w < SETTLE)       s_d[w] = s_r[w] ^ 16'h8001;
            if (mode == 5 && w == SETTLE + 4)  s_d[w] = s_r[w] ^ 16'h0100;
        end
    endtask

    task automatic check_zero(input int j);
        string p = $sformatf("i%0d_rst_", j);
        check_val({p, "rdy"},  {31'd0, in_ready[j]}, 32'd0);
        check_val({p, "cmp"},  {16'd0, cmp_count[j]}, 32'd0);
        check_val({p, "err"},  {16'd0, err_count[j]}, 32'd0);
        check_val({p, "flag"}, {31'd0, err_flag[j]}, 32'd0);
        check_val({p, "fa"},   {16'd0, first_a[j]}, 32'd0);
        check_val({p, "fr"},   {16'd0, first_ref[j]}, 32'd0);
        check_val({p, "fd"},   {16'd0, first_dut[j]}, 32'd0);
        check_val({p, "done"}, {31'd0, done[j]}, 32'd0);
        check_val({p, "pass"}, {31'd0, pass[j]}, 32'd0);
    endtask

    task automatic drive_word(input int j, input int idx, input bit ok);
        if (ok && idx < MAXW) begin
            a_v[j] = s_a[idx]; ref_v[j] = s_r[idx]; dut_v[j] = s_d[idx];
        end else begin
            a_v[j] = W'($urandom); ref_v[j] = W'($urandom); dut_v[j] = W'($urandom);
        end
    endtask

    // One run; abort_cyc >= 0 asserts rst in that cycle instead of finishing.
    task automatic run_test(input int num, input int mode, input int abort_cyc);
        int idx [2];
        bit fin [2];
        build_stream(mode);
        model(0, DRM_MASK_DEF, num);
        model(1, MASK_M, num);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check_val($sformatf("i%0d_rdy_before_start", j), {31'd0, in_ready[j]}, 32'd0);
            in_valid[j] = 1'($urandom_range(0, 1));
            drive_word(j, 0, 1'b1);
            idx[j] = 0;
            fin[j] = 1'b0;
        end
        start   = 1'b1;
        num_cmp = CNT_W'(num);
        @(posedge clk);
        for (int cyc = 0; cyc < 3000 && !(fin[0] && fin[1]); cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                in_valid[0] = 1'b0;
                in_valid[1] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_zero(0);
                check_zero(1);
                rst = 1'b0;
                return;
            end
            for (int j = 0; j < 2; j++) begin
                if (!fin[j]) begin
                    if (idx[j] == needed[j]) begin
                        check_val($sformatf("i%0d_done_rise", j), {31'd0, done[j]}, 32'd1);
                        fin[j] = 1'b1;
                    end else begin
                        check_val($sformatf("i%0d_done_early", j), {31'd0, done[j]}, 32'd0);
                        check_val($sformatf("i%0d_rdy_run", j), {31'd0, in_ready[j]}, 32'd1);
                    end
                end
                in_valid[j] = ($urandom_range(0, 99) < 70);
                drive_word(j, idx[j], !fin[j]);
            end
            // A start while both runs are active must be ignored.
            if (!fin[0] && !fin[1] && $urandom_range(0, 9) == 0) begin
                start   = 1'b1;
                num_cmp = CNT_W'($urandom);
            end
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (!fin[j] && in_valid[j] && idx[j] < needed[j]) idx[j]++;
            end
        end
        if (!(fin[0] && fin[1])) check_val("run_timeout", 32'd0, 32'd1);
        // Keep offering words: a finished monitor must not accept any.
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            for (int j = 0; j < 2; j++) begin
                in_valid[j] = 1'($urandom_range(0, 1));
                drive_word(j, 0, 1'b0);
            end
        end
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            string p = $sformatf("i%0d_m%0d_n%0d_", j, mode, num);
            check_val({p, "rdy"},  {31'd0, in_ready[j]}, 32'd0);
            check_val({p, "done"}, {31'd0, done[j]}, 32'd1);
            check_val({p, "pass"}, {31'd0, pass[j]}, {31'd0, !e_flag[j]});
            check_val({p, "cmp"},  {16'd0, cmp_count[j]}, {16'd0, e_cmp[j]});
            check_val({p, "err"},  {16'd0, err_count[j]}, {16'd0, e_err[j]});
            check_val({p, "flag"}, {31'd0, err_flag[j]}, {31'd0, e_flag[j]});
            check_val({p, "fa"},   {16'd0, first_a[j]}, {16'd0, e_fa[j]});
            check_val({p, "fr"},   {16'd0, first_ref[j]}, {16'd0, e_fr[j]});
            check_val({p, "fd"},   {16'd0, first_dut[j]}, {16'd0, e_fd[j]});
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        num_cmp = '0;
        for (int j = 0; j < 2; j++) begin
            in_valid[j] = 1'b0;
            a_v[j] = '0; ref_v[j] = '0; dut_v[j] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst = 1'b0;

        run_test(100, 0, -1);   // equal streams
        run_test(50,  1, -1);   // single fault in run word 37
        run_test(40,  2, -1);   // faults only in discarded settle words
        run_test(40,  3, -1);   // low-nibble differences: masked instance clean
        run_test(30,  5, -1);   // fault at compare 5
        run_test(50,  4, 20);   // reset mid-run
        run_test(50,  4, -1);   // clean run after reset
        run_test(0,   0, -1);   // zero compares
        for (int k = 0; k < 4; k++) begin
            run_test($urandom_range(1, 40), 4, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
